// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and frame data width.
// Kept separate so the transmitter can adopt the same constants later.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit.
// The reset value is a parameter so idle-high lines do not glitch out of reset.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronised rxd, mid-bit sampling, one-cycle
// rx_ready / ferr pulses with the received byte held on rdata.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_PER_HALF_BIT = 434
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rxd,
    output logic [UART_DATA_BITS-1:0] rdata,
    output logic                      rx_ready,
    output logic                      ferr,
    output logic                      rx_busy
);

    localparam int CNT_W = $clog2(2 * CLK_PER_HALF_BIT);
    localparam int IDX_W = $clog2(UART_DATA_BITS);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLK_PER_HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(2 * CLK_PER_HALF_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(UART_DATA_BITS - 1);

    rx_state_t                 state;
    logic [CNT_W-1:0]          cnt;
    logic [IDX_W-1:0]          bit_idx;
    logic [UART_DATA_BITS-1:0] shreg;
    logic                      rxs;

    sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (rxd),
        .q  (rxs)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            rdata    <= '0;
            rx_ready <= 1'b0;
            ferr     <= 1'b0;
            rx_busy  <= 1'b0;
        end else begin
            rx_ready <= 1'b0;
            ferr     <= 1'b0;
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (!rxs) begin
                        state   <= S_START;
                        rx_busy <= 1'b1;
                    end
                end
                // A start bit that is high again at its midpoint was noise.
                S_START: begin
                    if (cnt == HALF_END) begin
                        cnt <= '0;
                        if (rxs) begin
                            state   <= S_IDLE;
                            rx_busy <= 1'b0;
                        end else begin
                            state   <= S_DATA;
                            bit_idx <= '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt == BIT_END) begin
                        cnt     <= '0;
                        shreg   <= {rxs, shreg[UART_DATA_BITS-1:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == LAST_IDX) begin
                            state <= S_STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                // Leaving at the stop-bit midpoint lets a back-to-back start edge be seen.
                S_STOP: begin
                    if (cnt == BIT_END) begin
                        cnt   <= '0;
                        rdata <= shreg;
                        if (rxs) begin
                            rx_ready <= 1'b1;
                            state    <= S_IDLE;
                            rx_busy  <= 1'b0;
                        end else begin
                            ferr  <= 1'b1;
                            state <= S_WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WAIT_HIGH: begin
                    cnt <= '0;
                    if (rxs) begin
                        state   <= S_IDLE;
                        rx_busy <= 1'b0;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    cnt     <= '0;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 8 clocks per bit: frames push expected
// pulses, an independent monitor pops and checks them as the DUT emits them.
module tb_uart_rx;

    localparam int HALF = 4;
    localparam int BITC = 2 * HALF;

    typedef struct {
        logic       is_ferr;
        logic [7:0] data;
        int         start_cyc;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       rxd;
    logic [7:0] rdata;
    logic       rx_ready;
    logic       ferr;
    logic       rx_busy;

    exp_t sb[$];
    int   vec_count  = 0;
    int   miss_count = 0;
    int   cyc        = 0;
    int   ready_cnt  = 0;
    logic busy_seen  = 1'b0;
    int   ready_base;

    uart_rx #(
        .CLK_PER_HALF_BIT(HALF)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rxd     (rxd),
        .rdata   (rdata),
        .rx_ready(rx_ready),
        .ferr    (ferr),
        .rx_busy (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_busy) busy_seen = 1'b1;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            miss_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every DUT pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        exp_t e;
        int   lat;
        if (!rst && (rx_ready || ferr)) begin
            if (rx_ready) ready_cnt++;
            checkOutput("ready_ferr_exclusive", 32'(rx_ready & ferr), 32'd0);
            if (sb.size() == 0) begin
                checkOutput("unexpected_pulse", {30'd0, rx_ready, ferr}, 32'd0);
            end else begin
                e = sb.pop_front();
                checkOutput("pulse_is_ferr", 32'(ferr), 32'(e.is_ferr));
                checkOutput("pulse_rdata", 32'(rdata), 32'(e.data));
                if (!e.is_ferr) begin
                    lat = cyc - e.start_cyc;
                    vec_count++;
                    if (lat < 77 || lat > 79) begin
                        miss_count++;
                        $display("[TB] FAIL latency: got %0d cycles, expected 77..79", lat);
                    end
                end
            end
        end
    end

    // Drive rxd to v for n cycles; callers run at posedge + 1.
    task automatic hold(input logic v, input int n);
        rxd = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] b, input logic stop_bit);
        exp_t e;
        e.is_ferr   = ~stop_bit;
        e.data      = b;
        e.start_cyc = cyc;
        sb.push_back(e);
        hold(1'b0, BITC);
        for (int i = 0; i < 8; i++) hold(b[i], BITC);
        hold(stop_bit, BITC);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 300 && sb.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        checkOutput(name, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        rxd = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_rdata", 32'(rdata), 32'h00);
        checkOutput("reset_rx_ready", 32'(rx_ready), 32'd0);
        checkOutput("reset_ferr", 32'(ferr), 32'd0);
        checkOutput("reset_rx_busy", 32'(rx_busy), 32'd0);
        rst = 1'b0;

        busy_seen = 1'b0;
        hold(1'b1, 100);
        checkOutput("idle_busy_seen", 32'(busy_seen), 32'd0);
        checkOutput("idle_ready_cnt", 32'(ready_cnt), 32'd0);

        ready_base = ready_cnt;
        applyStimulus(8'h55, 1'b1);
        hold(1'b1, 16);
        drain("drain_55");
        checkOutput("rdata_55", 32'(rdata), 32'h55);
        checkOutput("busy_after_55", 32'(rx_busy), 32'd0);
        checkOutput("pulses_55", 32'(ready_cnt - ready_base), 32'd1);

        ready_base = ready_cnt;
        applyStimulus(8'hA3, 1'b1);
        applyStimulus(8'h0F, 1'b1);
        hold(1'b1, 16);
        drain("drain_b2b");
        checkOutput("pulses_b2b", 32'(ready_cnt - ready_base), 32'd2);
        checkOutput("rdata_0F", 32'(rdata), 32'h0F);

        ready_base = ready_cnt;
        busy_seen  = 1'b0;
        hold(1'b0, 2);
        hold(1'b1, 20);
        checkOutput("glitch_busy_seen", 32'(busy_seen), 32'd1);
        checkOutput("glitch_busy_after", 32'(rx_busy), 32'd0);
        checkOutput("glitch_pulses", 32'(ready_cnt - ready_base), 32'd0);
        applyStimulus(8'h7E, 1'b1);
        hold(1'b1, 16);
        drain("drain_7E");
        checkOutput("rdata_7E", 32'(rdata), 32'h7E);

        applyStimulus(8'h81, 1'b0);
        hold(1'b0, 40);
        drain("drain_81");
        checkOutput("ferr_rdata_81", 32'(rdata), 32'h81);
        checkOutput("break_busy", 32'(rx_busy), 32'd1);
        hold(1'b1, 5);
        checkOutput("break_released_busy", 32'(rx_busy), 32'd0);
        hold(1'b1, 16);
        applyStimulus(8'h3C, 1'b1);
        hold(1'b1, 16);
        drain("drain_3C");
        checkOutput("rdata_3C", 32'(rdata), 32'h3C);

        // 0xC6 aborted by a one-cycle reset midway through data bit 3.
        ready_base = ready_cnt;
        hold(1'b0, BITC);
        hold(1'b0, BITC);
        hold(1'b1, BITC);
        hold(1'b1, BITC);
        hold(1'b0, HALF);
        rst = 1'b1;
        rxd = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("abort_rdata", 32'(rdata), 32'h00);
        checkOutput("abort_busy", 32'(rx_busy), 32'd0);
        checkOutput("abort_ready", 32'(rx_ready), 32'd0);
        checkOutput("abort_ferr", 32'(ferr), 32'd0);
        hold(1'b1, 40);
        checkOutput("abort_pulses", 32'(ready_cnt - ready_base), 32'd0);
        applyStimulus(8'hC6, 1'b1);
        hold(1'b1, 16);
        drain("drain_C6");
        checkOutput("rdata_C6", 32'(rdata), 32'hC6);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
